uart_tx_configurable: RTL
=========================

# uart_tx_configurable

Parametrised successor to the fixed 8N1 UART transmitter. It serialises one character per write with a 1-cycle-granular baud divider. Data width (5..MAX_DATA_BITS), parity (none/even/odd) and stop-bit count (1/2) are selectable at run time. It sits between a host register/FIFO interface and the `serial_o` pin, and reports frame completion with a one-cycle `done_o` pulse.

## Interface
- `CLOCK_DIVIDER_WIDTH`, 16: width of `clock_divider_i`; clock cycles per bit.
- `MAX_DATA_BITS`, 9: widest character supported; legal range 5..9.
- `clock_i`  in  1  system clock, all state on rising edge.
- `reset_i`  in  1  asynchronous, active-high reset.
- `clock_divider_i`  in  CLOCK_DIVIDER_WIDTH  clock cycles per bit; 0 treated as 1.
- `data_bits_i`  in  4  character length; values <5 clamp to 5, values >MAX_DATA_BITS clamp to MAX_DATA_BITS.
- `parity_i`  in  2  0 = none, 1 = even, 2 = odd, 3 = none.
- `stop_bits_i`  in  1  0 = one stop bit, 1 = two stop bits.
- `write_i`  in  1  request to send `data_i`; honoured only when `busy_o` = 0.
- `data_i`  in  MAX_DATA_BITS  character, LSB sent first; bits at or above the effective length are ignored.
- `serial_o`  out  1  line output, idle/mark = 1; reset value 1.
- `busy_o`  out  1  combinational: 1 when state ≠ IDLE or `reset_i` = 1.
- `done_o`  out  1  one-cycle pulse at the end of the last stop bit; reset value 0.

## Operation
- States: POST_RESET, IDLE, START, DATA, PARITY, STOP.
- POST_RESET:
  - Entered on reset.
  - Holds `serial_o` = 1 for `1+MAX_DATA_BITS+1+2` bit periods, using the live divider, so a receiver cut off mid-frame times out.
  - Then moves to IDLE.
  - `write_i` is ignored.
- IDLE: `serial_o` = 1. When `write_i` = 1, latch `data_i`, the effective length N, the parity mode, the stop count and the effective divider D, then go to START.
- Config inputs change nothing mid-frame; only the latched copies are used.
- START: `serial_o` = 0 for D cycles, then DATA.
- DATA: sends bits 0..N-1 of the latched data, D cycles each. Next state is PARITY if parity is enabled, else STOP.
- PARITY: D cycles.
  - Even: bit = XOR of the N data bits.
  - Odd: bit = inverted XOR.
- STOP: `serial_o` = 1 for D cycles per stop bit (1 or 2). On the final cycle of the last stop bit, assert `done_o` and go to IDLE.
- A write while busy is dropped silently; it is not queued.
- Reset mid-frame:
  - `serial_o` goes to 1 immediately (asynchronous).
  - `done_o` goes to 0.
  - All counters clear and the block re-enters POST_RESET.
- An unreachable state encoding recovers to IDLE on the next edge.

## Timing
- Write-to-line latency: `write_i` is sampled high in IDLE at edge k, and `serial_o` falls at edge k (registered output visible after edge k).
- Each line bit lasts exactly D clock cycles.
- Frame length = D·(1 + N + P + S) cycles, where P ∈ {0,1} and S ∈ {1,2}.
- `done_o` is high for exactly one cycle, aligned with the last cycle of the final stop bit.
- The state is IDLE on the following edge, so `busy_o` is 0 one cycle after `done_o`.
- Minimum inter-frame gap is one IDLE cycle of mark, in addition to the stop bits.
- Bit timer: counts 0..D-1 at CLOCK_DIVIDER_WIDTH bits and wraps to 0 on the terminal count. D = max(`clock_divider_i`, 1) is computed without underflow.
- Bit index counter: 4 bits, compared against the latched N.
- POST_RESET bit counter: 4 bits; it must not overflow for MAX_DATA_BITS = 9, where the count is 13.

## Structure
- Shared package `uart_pkg`:
  - state enum;
  - parity constants PARITY_NONE/EVEN/ODD;
  - MIN_DATA_BITS = 5;
  - function computing effective N and D (clamping).
- Sub-module `uart_bit_timer`:
  - loadable divider;
  - `tick_o` on terminal count;
  - `clear_i` restarts the count.
- The receiver successor will reuse the same timer.

## Test plan
- D = 4, N = 8, no parity, 1 stop, `data_i` = 0x55 → line 0,1,0,1,0,1,0,1,0,1 (4 cycles each); 40-cycle frame; `done_o` pulse at cycle 40.
- D = 3, N = 7, even parity, 2 stop, `data_i` = 0x07 → 7 data bits, then parity bit 1, then 6 mark cycles; 33-cycle frame.
- Odd parity, N = 5, `data_i` = 0x1F → parity bit 0. Then `data_bits_i` = 2 → frame uses N = 5. Then `data_bits_i` = 15 with MAX = 9 → frame uses N = 9.
- `clock_divider_i` = 0 → every bit lasts 1 cycle. Changing the divider, parity and data inputs mid-frame does not alter the frame in flight.
- `write_i` held high throughout → back-to-back frames separated by exactly one idle cycle. A write pulse during a frame produces no extra frame.
- Assert `reset_i` during DATA → `serial_o` = 1 and `busy_o` = 1 immediately. The line stays high for 13·D cycles after release; the first accepted write then transmits correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART transmitter and its
// companion receiver: state encoding, parity codes and run-time clamping.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_POST_RESET = 3'd0,
        ST_IDLE       = 3'd1,
        ST_START      = 3'd2,
        ST_DATA       = 3'd3,
        ST_PARITY     = 3'd4,
        ST_STOP       = 3'd5
    } uart_state_e;

    localparam logic [1:0] PARITY_NONE = 2'd0;
    localparam logic [1:0] PARITY_EVEN = 2'd1;
    localparam logic [1:0] PARITY_ODD  = 2'd2;

    localparam int MIN_DATA_BITS = 5;

    // Divider arithmetic is done at this width; divider ports may not exceed it.
    localparam int DIVIDER_CALC_WIDTH = 32;

    function automatic logic [3:0] effective_data_bits(input logic [3:0] requested,
                                                       input logic [3:0] max_bits);
        if (requested < 4'(MIN_DATA_BITS)) begin
            return 4'(MIN_DATA_BITS);
        end else if (requested > max_bits) begin
            return max_bits;
        end else begin
            return requested;
        end
    endfunction

    // A divider of zero means one clock per bit; no subtraction, so no underflow.
    function automatic logic [DIVIDER_CALC_WIDTH-1:0] effective_divider(
        input logic [DIVIDER_CALC_WIDTH-1:0] requested);
        if (requested == '0) begin
            return DIVIDER_CALC_WIDTH'(1);
        end else begin
            return requested;
        end
    endfunction

endpackage

// File: rtl/uart_tx_configurable_bit_timer.sv
// Bit-period timer shared by the UART transmitter and receiver: counts
// 0..divider-1, pulses tick_o on the terminal count and wraps.
module uart_bit_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] divider_i,
    output logic             tick_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // divider_i is never zero here; ">=" also recovers if the divider shrinks mid-count.
    always_comb begin
        tick_o = (count_q >= (divider_i - WIDTH'(1)));
        if (clear_i || tick_o) begin
            count_d = '0;
        end else begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx_configurable.sv
// Run-time configurable UART transmitter (5..MAX_DATA_BITS data bits,
// none/even/odd parity, 1 or 2 stop bits) with a post-reset mark period.
module uart_tx_configurable
    import uart_pkg::*;
#(
    parameter int CLOCK_DIVIDER_WIDTH = 16,
    parameter int MAX_DATA_BITS       = 9
) (
    input  logic                           clock_i,
    input  logic                           reset_i,
    input  logic [CLOCK_DIVIDER_WIDTH-1:0] clock_divider_i,
    input  logic [3:0]                     data_bits_i,
    input  logic [1:0]                     parity_i,
    input  logic                           stop_bits_i,
    input  logic                           write_i,
    input  logic [MAX_DATA_BITS-1:0]       data_i,
    output logic                           serial_o,
    output logic                           busy_o,
    output logic                           done_o
);

    localparam int         DW              = CLOCK_DIVIDER_WIDTH;
    localparam logic [3:0] MAX_BITS        = 4'(MAX_DATA_BITS);
    localparam logic [3:0] POST_RESET_LAST = 4'(1 + MAX_DATA_BITS + 1 + 2 - 1);

    uart_state_e              state_q, state_d;
    logic [MAX_DATA_BITS-1:0] data_q, data_d;
    logic [3:0]               n_q, n_d;
    logic [3:0]               bit_idx_q, bit_idx_d;
    logic [1:0]               parity_q, parity_d;
    logic                     stop2_q, stop2_d;
    logic [DW-1:0]            div_q, div_d;
    logic                     serial_q, serial_d;

    logic [DW-1:0]            div_live;
    logic [DW-1:0]            timer_div;
    logic [3:0]               n_live;
    logic [MAX_DATA_BITS-1:0] live_mask;
    logic                     tick;
    logic                     parity_on;
    logic [3:0]               stop_last;
    logic                     data_bit;
    logic                     parity_bit;

    assign div_live  = DW'(effective_divider(DIVIDER_CALC_WIDTH'(clock_divider_i)));
    assign n_live    = effective_data_bits(data_bits_i, MAX_BITS);
    assign parity_on = (parity_q == PARITY_EVEN) || (parity_q == PARITY_ODD);
    assign stop_last = stop2_q ? 4'd1 : 4'd0;

    // The post-reset mark period follows the live divider; frames use the latched one.
    assign timer_div = (state_q == ST_POST_RESET) ? div_live : div_q;

    always_comb begin
        live_mask = '0;
        for (int i = 0; i < MAX_DATA_BITS; i++) begin
            live_mask[i] = (i < int'(n_live));
        end
    end

    uart_bit_timer #(
        .WIDTH(DW)
    ) u_bit_timer (
        .clock_i  (clock_i),
        .reset_i  (reset_i),
        .clear_i  (state_q == ST_IDLE),
        .divider_i(timer_div),
        .tick_o   (tick)
    );

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= ST_POST_RESET;
            data_q    <= '0;
            n_q       <= '0;
            bit_idx_q <= '0;
            parity_q  <= PARITY_NONE;
            stop2_q   <= 1'b0;
            div_q     <= DW'(1);
            serial_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            n_q       <= n_d;
            bit_idx_q <= bit_idx_d;
            parity_q  <= parity_d;
            stop2_q   <= stop2_d;
            div_q     <= div_d;
            serial_q  <= serial_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        n_d       = n_q;
        bit_idx_d = bit_idx_q;
        parity_d  = parity_q;
        stop2_d   = stop2_q;
        div_d     = div_q;
        case (state_q)
            ST_POST_RESET: begin
                if (tick) begin
                    if (bit_idx_q == POST_RESET_LAST) begin
                        state_d   = ST_IDLE;
                        bit_idx_d = '0;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
            end
            ST_IDLE: begin
                if (write_i) begin
                    state_d   = ST_START;
                    data_d    = data_i & live_mask;
                    n_d       = n_live;
                    parity_d  = parity_i;
                    stop2_d   = stop_bits_i;
                    div_d     = div_live;
                    bit_idx_d = '0;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_idx_q == (n_q - 4'd1)) begin
                        state_d   = parity_on ? ST_PARITY : ST_STOP;
                        bit_idx_d = '0;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_d   = ST_STOP;
                    bit_idx_d = '0;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (bit_idx_q == stop_last) begin
                        state_d   = ST_IDLE;
                        bit_idx_d = '0;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bit_idx_d = '0;
            end
        endcase
    end

    // serial_d is the line level for the next state, so the line changes on the same edge.
    always_comb begin
        data_bit = 1'b0;
        for (int i = 0; i < MAX_DATA_BITS; i++) begin
            if (4'(i) == bit_idx_d) begin
                data_bit = data_d[i];
            end
        end
        parity_bit = (^data_d) ^ (parity_d == PARITY_ODD);
        case (state_d)
            ST_START:  serial_d = 1'b0;
            ST_DATA:   serial_d = data_bit;
            ST_PARITY: serial_d = parity_bit;
            default:   serial_d = 1'b1;
        endcase
        done_o = (state_q == ST_STOP) && tick && (bit_idx_q == stop_last);
        busy_o = reset_i || (state_q != ST_IDLE);
    end

    assign serial_o = serial_q;

endmodule
